// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions: transfer types, responses and the master index
// used by the two-master arbiter.
package ahbl_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_t;

   typedef logic master_idx_t;
   localparam master_idx_t MASTER0 = 1'b0;
   localparam master_idx_t MASTER1 = 1'b1;

   // A master only sees the slave's HREADY while it owns the address phase or
   // the in-flight data phase; a stalled NONSEQ is held with HREADY low.
   function automatic logic master_ready(input logic       in_reset,
                                         input logic       is_owner,
                                         input logic       in_data_phase,
                                         input logic [1:0] htrans,
                                         input logic       hready);
      logic rdy;
      rdy = 1'b1;
      if (in_reset)
         rdy = 1'b1;
      else if (is_owner || in_data_phase)
         rdy = hready;
      else if (htrans == HTRANS_NONSEQ)
         rdy = 1'b0;
      return rdy;
   endfunction

endpackage

// File: rtl/ahbl_master_arbiter_if.sv
// One AHB-Lite bus segment; the master modport drives address/control/write
// data, the slave modport returns read data, ready and response.
interface ahbl_master_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] HADDR;
   logic [1:0]            HTRANS;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [3:0]            HPROT;
   logic                  HMASTLOCK;
   logic [DATA_WIDTH-1:0] HWDATA;
   logic [DATA_WIDTH-1:0] HRDATA;
   logic                  HREADY;
   logic                  HRESP;

   modport master (
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/ahbl_rr_arb2.sv
// Address-phase grant for two masters: the owner keeps the bus while active or
// locked; on a free accepted cycle a waiting NONSEQ takes over, alternating.
module ahbl_rr_arb2
   import ahbl_pkg::*;
#(
   parameter bit DEFAULT_MASTER = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  htrans0,
   input  logic [1:0]  htrans1,
   input  logic        lock0,
   input  logic        lock1,
   input  logic        hready,
   output master_idx_t owner
);

   logic [1:0]  htrans_v [2];
   logic [1:0]  lock_v;
   logic [1:0]  req_v;
   master_idx_t owner_reg;
   master_idx_t owner_next;
   master_idx_t last_grant_reg;
   master_idx_t last_grant_next;
   master_idx_t other_grant;
   logic        owner_busy;

   assign htrans_v[0] = htrans0;
   assign htrans_v[1] = htrans1;
   assign lock_v      = {lock1, lock0};
   assign other_grant = ~last_grant_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         assign req_v[gi] = (htrans_v[gi] == HTRANS_NONSEQ);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_reg      <= DEFAULT_MASTER;
         last_grant_reg <= DEFAULT_MASTER;
      end else begin
         owner_reg      <= owner_next;
         last_grant_reg <= last_grant_next;
      end
   end

   // IDLE cycles inside a locked sequence still count as busy.
   always_comb begin
      owner_next      = owner_reg;
      last_grant_next = last_grant_reg;
      owner_busy      = (htrans_v[owner_reg] != HTRANS_IDLE) || lock_v[owner_reg];
      if (hready && !owner_busy && req_v[other_grant]) begin
         owner_next      = other_grant;
         last_grant_next = other_grant;
      end
   end

   assign owner = owner_reg;

endmodule

// File: rtl/ahbl_master_arbiter.sv
// Two-master AHB-Lite arbiter: muxes the address phase from the grant owner
// and routes write data and responses by the registered data-phase owner.
module ahbl_master_arbiter
   import ahbl_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter bit DEFAULT_MASTER = 1'b0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   ahbl_master_arbiter_if.slave  m0,
   ahbl_master_arbiter_if.slave  m1,
   ahbl_master_arbiter_if.master bus,
   output logic                  GRANT
);

   master_idx_t           addr_owner;
   master_idx_t           data_owner_reg;
   logic                  data_active_reg;
   logic [ADDR_WIDTH-1:0] haddr_mux;
   logic [DATA_WIDTH-1:0] hwdata_mux;
   logic [1:0]            htrans_mux;
   logic                  m0_data;
   logic                  m1_data;

   ahbl_rr_arb2 #(
      .DEFAULT_MASTER(DEFAULT_MASTER)
   ) u_arb (
      .clk    (HCLK),
      .rst    (HRESET),
      .htrans0(m0.HTRANS),
      .htrans1(m1.HTRANS),
      .lock0  (m0.HMASTLOCK),
      .lock1  (m1.HMASTLOCK),
      .hready (bus.HREADY),
      .owner  (addr_owner)
   );

   // Data phase follows the address phase accepted at each ready edge.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         data_owner_reg  <= DEFAULT_MASTER;
         data_active_reg <= 1'b0;
      end else if (bus.HREADY) begin
         data_owner_reg  <= addr_owner;
         data_active_reg <= htrans_mux[1];
      end
   end

   assign haddr_mux  = (addr_owner == MASTER1) ? m1.HADDR  : m0.HADDR;
   assign htrans_mux = (addr_owner == MASTER1) ? m1.HTRANS : m0.HTRANS;
   assign hwdata_mux = (data_owner_reg == MASTER1) ? m1.HWDATA : m0.HWDATA;

   assign bus.HADDR     = haddr_mux;
   assign bus.HTRANS    = HRESET ? HTRANS_IDLE : htrans_mux;
   assign bus.HWRITE    = (addr_owner == MASTER1) ? m1.HWRITE    : m0.HWRITE;
   assign bus.HSIZE     = (addr_owner == MASTER1) ? m1.HSIZE     : m0.HSIZE;
   assign bus.HBURST    = (addr_owner == MASTER1) ? m1.HBURST    : m0.HBURST;
   assign bus.HPROT     = (addr_owner == MASTER1) ? m1.HPROT     : m0.HPROT;
   assign bus.HMASTLOCK = (addr_owner == MASTER1) ? m1.HMASTLOCK : m0.HMASTLOCK;
   assign bus.HWDATA    = hwdata_mux;

   assign m0_data = data_active_reg && (data_owner_reg == MASTER0);
   assign m1_data = data_active_reg && (data_owner_reg == MASTER1);

   assign m0.HRDATA = bus.HRDATA;
   assign m1.HRDATA = bus.HRDATA;
   assign m0.HREADY = master_ready(HRESET, addr_owner == MASTER0, m0_data,
                                   m0.HTRANS, bus.HREADY);
   assign m1.HREADY = master_ready(HRESET, addr_owner == MASTER1, m1_data,
                                   m1.HTRANS, bus.HREADY);
   assign m0.HRESP  = m0_data ? bus.HRESP : HRESP_OKAY;
   assign m1.HRESP  = m1_data ? bus.HRESP : HRESP_OKAY;

   assign GRANT = addr_owner;

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Directed bench for the two-master arbiter: a cycle model of ownership and
// data phase checked every cycle, plus literal expectations per scenario.
module tb_ahbl_master_arbiter;
   import ahbl_pkg::*;

   logic HCLK = 1'b0;
   logic HRESET;
   logic GRANT;
   int   n_checks = 0;
   int   n_fail   = 0;

   int   mdl_owner   = 0;
   int   mdl_dmaster = 0;
   bit   mdl_dactive = 1'b0;

   ahbl_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
   ahbl_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
   ahbl_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();

   ahbl_master_arbiter #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .DEFAULT_MASTER(1'b0)
   ) dut (
      .HCLK  (HCLK),
      .HRESET(HRESET),
      .m0    (m0_bus),
      .m1    (m1_bus),
      .bus   (s_bus),
      .GRANT (GRANT)
   );

   always #5 HCLK = ~HCLK;

   function automatic logic [1:0] tr_of(input int n);
      return (n == 1) ? m1_bus.HTRANS : m0_bus.HTRANS;
   endfunction
   function automatic logic lock_of(input int n);
      return (n == 1) ? m1_bus.HMASTLOCK : m0_bus.HMASTLOCK;
   endfunction
   function automatic logic [31:0] addr_of(input int n);
      return (n == 1) ? m1_bus.HADDR : m0_bus.HADDR;
   endfunction
   function automatic logic wr_of(input int n);
      return (n == 1) ? m1_bus.HWRITE : m0_bus.HWRITE;
   endfunction
   function automatic logic [2:0] burst_of(input int n);
      return (n == 1) ? m1_bus.HBURST : m0_bus.HBURST;
   endfunction
   function automatic logic [31:0] wd_of(input int n);
      return (n == 1) ? m1_bus.HWDATA : m0_bus.HWDATA;
   endfunction
   function automatic logic rdy_of(input int n);
      return (n == 1) ? m1_bus.HREADY : m0_bus.HREADY;
   endfunction
   function automatic logic resp_of(input int n);
      return (n == 1) ? m1_bus.HRESP : m0_bus.HRESP;
   endfunction
   function automatic logic [31:0] rd_of(input int n);
      return (n == 1) ? m1_bus.HRDATA : m0_bus.HRDATA;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the bus changes hands only after an accepted, unlocked IDLE from
   // the owner while the other master waits with NONSEQ.
   always @(posedge HCLK) begin
      if (HRESET) begin
         mdl_owner   <= 0;
         mdl_dmaster <= 0;
         mdl_dactive <= 1'b0;
      end else if (s_bus.HREADY) begin
         mdl_dactive <= (tr_of(mdl_owner) >= 2'b10);
         mdl_dmaster <= mdl_owner;
         if (tr_of(mdl_owner) == 2'b00 && !lock_of(mdl_owner) && tr_of(1 - mdl_owner) == 2'b10)
            mdl_owner <= 1 - mdl_owner;
      end
   end

   always @(negedge HCLK) begin : compare
      logic e_rdy;
      logic e_resp;
      if (HRESET) begin
         chk("rst_htrans", 32'(s_bus.HTRANS), 32'd0);
         chk("rst_grant", 32'(GRANT), 32'd0);
         for (int n = 0; n < 2; n++) begin
            chk($sformatf("rst_m%0d_hready", n), 32'(rdy_of(n)), 32'd1);
            chk($sformatf("rst_m%0d_hresp", n), 32'(resp_of(n)), 32'd0);
         end
      end else begin
         chk("grant", 32'(GRANT), 32'(mdl_owner));
         chk("htrans", 32'(s_bus.HTRANS), 32'(tr_of(mdl_owner)));
         chk("haddr", s_bus.HADDR, addr_of(mdl_owner));
         chk("hwrite", 32'(s_bus.HWRITE), 32'(wr_of(mdl_owner)));
         chk("hburst", 32'(s_bus.HBURST), 32'(burst_of(mdl_owner)));
         chk("hmastlock", 32'(s_bus.HMASTLOCK), 32'(lock_of(mdl_owner)));
         if (mdl_dactive)
            chk("hwdata", s_bus.HWDATA, wd_of(mdl_dmaster));
         for (int n = 0; n < 2; n++) begin
            if (n == mdl_owner || (mdl_dactive && n == mdl_dmaster))
               e_rdy = s_bus.HREADY;
            else
               e_rdy = (tr_of(n) == 2'b10) ? 1'b0 : 1'b1;
            e_resp = (mdl_dactive && n == mdl_dmaster) ? s_bus.HRESP : 1'b0;
            chk($sformatf("m%0d_hready", n), 32'(rdy_of(n)), 32'(e_rdy));
            chk($sformatf("m%0d_hresp", n), 32'(resp_of(n)), 32'(e_resp));
            chk($sformatf("m%0d_hrdata", n), rd_of(n), s_bus.HRDATA);
         end
      end
   end

   task automatic drv(input int n, input logic [1:0] tr, input logic [31:0] a,
                      input logic w, input logic [2:0] b, input logic lk);
      if (n == 0) begin
         m0_bus.HTRANS = tr; m0_bus.HADDR = a; m0_bus.HWRITE = w;
         m0_bus.HBURST = b; m0_bus.HMASTLOCK = lk;
      end else begin
         m1_bus.HTRANS = tr; m1_bus.HADDR = a; m1_bus.HWRITE = w;
         m1_bus.HBURST = b; m1_bus.HMASTLOCK = lk;
      end
   endtask

   task automatic idle(input int n);
      drv(n, HTRANS_IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
   endtask

   task automatic wd(input int n, input logic [31:0] d);
      if (n == 0) m0_bus.HWDATA = d;
      else        m1_bus.HWDATA = d;
   endtask

   task automatic slv(input logic rdy, input logic rsp, input logic [31:0] rd);
      s_bus.HREADY = rdy; s_bus.HRESP = rsp; s_bus.HRDATA = rd;
   endtask

   task automatic nxt();
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      HRESET = 1'b1;
      m0_bus.HSIZE = 3'b010; m0_bus.HPROT = 4'h3; m0_bus.HWDATA = 32'h0;
      m1_bus.HSIZE = 3'b001; m1_bus.HPROT = 4'h1; m1_bus.HWDATA = 32'h0;
      slv(1'b1, 1'b0, 32'h1234_5678);
      drv(0, HTRANS_NONSEQ, 32'h10, 1'b0, 3'b000, 1'b0);
      drv(1, HTRANS_NONSEQ, 32'h20, 1'b0, 3'b000, 1'b0);
      @(negedge HCLK);
      chk("reset_htrans", 32'(s_bus.HTRANS), 32'd0);
      chk("reset_m0_hready", 32'(m0_bus.HREADY), 32'd1);
      chk("reset_m1_hready", 32'(m1_bus.HREADY), 32'd1);
      chk("reset_m1_hresp", 32'(m1_bus.HRESP), 32'd0);
      chk("reset_grant", 32'(GRANT), 32'd0);

      nxt(); HRESET = 1'b0; idle(0); idle(1);
      // Single zero-wait write from M0
      nxt(); drv(0, HTRANS_NONSEQ, 32'h0000_0100, 1'b1, 3'b000, 1'b0);
      @(negedge HCLK);
      chk("wr_haddr", s_bus.HADDR, 32'h0000_0100);
      chk("wr_m1_hready_a", 32'(m1_bus.HREADY), 32'd1);
      nxt(); idle(0); wd(0, 32'hA5A5_0000);
      @(negedge HCLK);
      chk("wr_hwdata", s_bus.HWDATA, 32'hA5A5_0000);
      chk("wr_m1_hready_d", 32'(m1_bus.HREADY), 32'd1);

      // Contention one cycle after reset
      nxt(); HRESET = 1'b1;
      nxt(); HRESET = 1'b0;
      nxt();
      drv(0, HTRANS_NONSEQ, 32'h180, 1'b1, 3'b000, 1'b0);
      drv(1, HTRANS_NONSEQ, 32'h200, 1'b0, 3'b000, 1'b0);
      @(negedge HCLK);
      chk("cont_grant0", 32'(GRANT), 32'd0);
      chk("cont_m1_stall", 32'(m1_bus.HREADY), 32'd0);
      nxt(); idle(0); wd(0, 32'h1111_2222);
      @(negedge HCLK);
      chk("cont_m1_stall_idle", 32'(m1_bus.HREADY), 32'd0);
      chk("cont_hwdata", s_bus.HWDATA, 32'h1111_2222);
      nxt(); slv(1'b0, 1'b0, 32'h0);
      @(negedge HCLK);
      chk("cont_grant1", 32'(GRANT), 32'd1);
      chk("cont_haddr1", s_bus.HADDR, 32'h200);
      chk("cont_m1_wait", 32'(m1_bus.HREADY), 32'd0);
      nxt(); slv(1'b1, 1'b0, 32'h0);
      @(negedge HCLK);
      chk("cont_m1_ready", 32'(m1_bus.HREADY), 32'd1);
      nxt(); idle(1); slv(1'b1, 1'b0, 32'hCAFE_0001);
      @(negedge HCLK);
      chk("cont_m0_hrdata", m0_bus.HRDATA, 32'hCAFE_0001);

      // INCR4 burst from M0 with M1 waiting from the second beat
      nxt(); drv(0, HTRANS_NONSEQ, 32'h300, 1'b1, 3'b011, 1'b0);
      @(negedge HCLK);
      chk("burst_m0_stall", 32'(m0_bus.HREADY), 32'd0);
      nxt(); wd(0, 32'hB000_0000);
      @(negedge HCLK);
      chk("burst_grant0", 32'(GRANT), 32'd0);
      for (int k = 1; k < 4; k++) begin
         nxt();
         drv(0, HTRANS_SEQ, 32'h300 + 32'(4 * k), 1'b1, 3'b011, 1'b0);
         wd(0, 32'hB000_0000 + 32'(k));
         drv(1, HTRANS_NONSEQ, 32'h400, 1'b0, 3'b000, 1'b0);
         @(negedge HCLK);
         chk("burst_beat_grant", 32'(GRANT), 32'd0);
         chk("burst_beat_haddr", s_bus.HADDR, 32'h300 + 32'(4 * k));
         chk("burst_m1_held", 32'(m1_bus.HREADY), 32'd0);
      end
      nxt(); idle(0); wd(0, 32'hB000_0004);
      @(negedge HCLK);
      chk("burst_end_grant", 32'(GRANT), 32'd0);
      nxt();
      @(negedge HCLK);
      chk("burst_handover", 32'(GRANT), 32'd1);
      chk("burst_m1_haddr", s_bus.HADDR, 32'h400);

      // Locked sequence from M0 with an IDLE inside the lock
      nxt(); idle(1); drv(0, HTRANS_NONSEQ, 32'h500, 1'b1, 3'b000, 1'b1);
      nxt();
      @(negedge HCLK);
      chk("lock_grant0", 32'(GRANT), 32'd0);
      nxt(); drv(0, HTRANS_IDLE, 32'h0, 1'b0, 3'b000, 1'b1);
      drv(1, HTRANS_NONSEQ, 32'h600, 1'b1, 3'b000, 1'b0); wd(1, 32'h6666_0000);
      nxt(); drv(0, HTRANS_NONSEQ, 32'h504, 1'b1, 3'b000, 1'b1);
      @(negedge HCLK);
      chk("lock_hold_grant", 32'(GRANT), 32'd0);
      chk("lock_m1_held", 32'(m1_bus.HREADY), 32'd0);
      nxt(); idle(0);
      @(negedge HCLK);
      chk("lock_release_grant", 32'(GRANT), 32'd0);
      nxt();
      @(negedge HCLK);
      chk("lock_handover", 32'(GRANT), 32'd1);
      chk("lock_m1_haddr", s_bus.HADDR, 32'h600);

      // M1 read: two wait states then a two-cycle ERROR
      nxt(); idle(1);
      nxt(); drv(1, HTRANS_NONSEQ, 32'h700, 1'b0, 3'b000, 1'b0);
      nxt(); idle(1); slv(1'b0, 1'b0, 32'h0);
      nxt();
      @(negedge HCLK);
      chk("err_m1_wait", 32'(m1_bus.HREADY), 32'd0);
      nxt(); slv(1'b0, 1'b1, 32'h0);
      @(negedge HCLK);
      chk("err1_m1_hresp", 32'(m1_bus.HRESP), 32'd1);
      chk("err1_m0_hresp", 32'(m0_bus.HRESP), 32'd0);
      nxt(); slv(1'b1, 1'b1, 32'h0);
      @(negedge HCLK);
      chk("err2_m1_hresp", 32'(m1_bus.HRESP), 32'd1);
      chk("err2_m0_hresp", 32'(m0_bus.HRESP), 32'd0);
      nxt(); slv(1'b1, 1'b0, 32'h0);
      @(negedge HCLK);
      chk("err_done_m1_hresp", 32'(m1_bus.HRESP), 32'd0);

      // Reset asserted during a slave wait state
      nxt(); drv(1, HTRANS_NONSEQ, 32'h800, 1'b0, 3'b000, 1'b0);
      nxt(); idle(1); slv(1'b0, 1'b1, 32'h0);
      @(negedge HCLK);
      chk("rw_m1_wait", 32'(m1_bus.HREADY), 32'd0);
      #2;
      HRESET = 1'b1;
      drv(1, HTRANS_NONSEQ, 32'h900, 1'b0, 3'b000, 1'b0);
      #1;
      chk("rw_grant", 32'(GRANT), 32'd0);
      chk("rw_htrans", 32'(s_bus.HTRANS), 32'd0);
      chk("rw_m1_hready", 32'(m1_bus.HREADY), 32'd1);
      chk("rw_m1_hresp", 32'(m1_bus.HRESP), 32'd0);
      nxt(); HRESET = 1'b0; idle(1); slv(1'b1, 1'b0, 32'h0);
      @(negedge HCLK);
      chk("post_rst_grant", 32'(GRANT), 32'd0);
      nxt();
      nxt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ahbl_master_arbiter.md
# ahbl_master_arbiter

Two-master AHB-Lite arbiter that lets the AHB-Lite BFM share one AHB-Lite slave-side bus with a second master, such as a DMA or a second BFM instance. It sits between the masters and the address decoder/slave multiplexer. It grants the address phase round-robin, holds grants across bursts and locked sequences, and routes write data and responses using a registered data-phase owner. A master that is not granted is stalled through its own HREADY.

## Interface
- ADDR_WIDTH, 32, width of HADDR on all ports
- DATA_WIDTH, 32, width of HWDATA/HRDATA
- DEFAULT_MASTER, 0, parking owner after reset (0 or 1)

Ports:
- HCLK  in  1  the single clock
- HRESET  in  1  asynchronous, active-high reset
- Mn_HADDR, Mn_HTRANS, Mn_HWRITE, Mn_HSIZE, Mn_HBURST, Mn_HPROT, Mn_HMASTLOCK, Mn_HWDATA  in  ADDR_WIDTH/2/1/3/3/4/1/DATA_WIDTH  master n address/control/write data (n = 0, 1)
- Mn_HRDATA  out  DATA_WIDTH  read data to master n
- Mn_HREADY  out  1  ready to master n
- Mn_HRESP  out  1  response to master n
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA  out  same widths  muxed slave-side bus
- HRDATA  in  DATA_WIDTH  slave read data
- HREADY  in  1  slave-side ready (HREADYOUT of selected slave)
- HRESP  in  1  slave-side response
- GRANT  out  1  current address-phase owner (debug)

## Operation
- State registers:
  - addr_owner (1 bit)
  - data_owner (1 bit)
  - data_active (1 bit; data phase belongs to a NONSEQ/SEQ)
  - last_grant (1 bit)
- Address mux: the slave-side address/control signals are driven from the addr_owner master.
- Request: a non-owner requests the bus when its HTRANS = NONSEQ.
- Owner keeps the bus while any of these is true:
  - its HTRANS is NONSEQ, SEQ or BUSY;
  - its HMASTLOCK = 1.
- Handover: at a rising edge with HREADY = 1, owner HTRANS = IDLE, owner HMASTLOCK = 0 and the other master requesting, addr_owner flips and last_grant updates.
- Parking: with no requests, addr_owner is unchanged.
- Simultaneous requests during handover eligibility go to the master that is not last_grant, i.e. strict alternation.
- On each edge with HREADY = 1:
  - data_owner <= addr_owner;
  - data_active <= HTRANS[1].
- HWDATA is muxed by data_owner.
- HRDATA is broadcast to both masters.
- Mn_HRESP = HRESP when n = data_owner and data_active, else 0.
- Mn_HREADY:
  - owner: HREADY;
  - non-owner with HTRANS = NONSEQ: 0 (stalled; it must hold its address phase);
  - non-owner otherwise: 1.
- Exception: if n = data_owner with data_active while not the owner, Mn_HREADY = HREADY until that data phase completes.
- ERROR response (two cycles) goes only to the data-phase owner. Grant rules are unchanged.

## Timing
- Reset (async assert, sync-to-HCLK deassert by the system):
  - addr_owner = data_owner = last_grant = DEFAULT_MASTER;
  - data_active = 0;
  - during reset, HTRANS forced to IDLE, both Mn_HREADY = 1, both Mn_HRESP = 0, GRANT = DEFAULT_MASTER.
- Address/control mux: zero-cycle combinational from the owner.
- Handover latency: a stalled NONSEQ reaches the bus in the cycle after the owner's first non-locked IDLE accepted with HREADY = 1. Minimum one IDLE bus cycle between owners.
- No switch is allowed mid-burst (SEQ/BUSY) or under HMASTLOCK, even with IDLE cycles inside the locked sequence.
- Slave wait states (HREADY = 0) freeze all registers.
- Reset mid-transfer aborts it; no completion is reported to either master.

## Structure
- Shared package `ahbl_pkg`:
  - HTRANS constants (IDLE = 00, BUSY = 01, NONSEQ = 10, SEQ = 11);
  - HRESP constants OKAY/ERROR;
  - master-index typedef.
- Sub-module: `ahbl_rr_arb2` holds the grant decision and the last_grant register. The top level holds the data-phase registers and the muxes.

## Test plan
- Reset: hold HRESET = 1 with both masters driving NONSEQ. Expect HTRANS = 00, M0_HREADY = M1_HREADY = 1, both HRESP = 0, GRANT = 0.
- Single write: M0 writes 0x0000_0100 with data 0xA5A5_0000, zero-wait slave.
  - Expect HADDR = 0x100 in the address cycle and HWDATA = 0xA5A5_0000 in the next cycle.
  - Expect M1_HREADY = 1 throughout.
- Contention: M0 and M1 both issue NONSEQ one cycle after reset.
  - M0 goes first and M1_HREADY = 0.
  - After M0 drives IDLE, M1's address appears one cycle later and M1_HREADY follows HREADY.
- Burst: M0 runs an INCR4 burst with M1 requesting from beat 1. Expect four M0 beats uninterrupted, then M1 is granted.
- Lock: M0 sends NONSEQ with HMASTLOCK = 1, IDLE (still locked), then NONSEQ. Expect M1 held off until M0 HMASTLOCK = 0 with IDLE.
- Error and reset:
  - M1 read with 2 wait states then an ERROR response: expect M1_HRESP = 1 for 2 cycles and M0_HRESP = 0.
  - HRESET asserted during a wait state: expect immediate return to reset values.
